// File: rtl/lc3_op_sequencer.sv
// LC-3 ADD/AND/NOT sequencer: IDLE -> READ -> EXEC -> WB, or IDLE -> ILL.
// Define LC3_OP_SEQUENCER_IMM5_EN to enable imm5 operands for ADD/AND.
module lc3_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [15:0] inst,
  output logic        inst_ready,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  input  logic [15:0] rf_rd1,
  input  logic [15:0] rf_rd2,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  output logic        rf_we,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_wd,
  output logic [2:0]  cc,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ILL
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [2:0]  dr_q;
  logic        ready_q;
  logic [2:0]  sr1_q, sr2_q;
  logic [3:0]  alu_op_q;
  logic [15:0] alu_a_q, alu_b_q;
  logic        we_q, done_q, ill_q;
  logic [2:0]  rf_dr_q;
  logic [2:0]  cc_q;
  logic        legal_d;
  logic [15:0] opb_d;
  logic [2:0]  cc_d;

`ifdef LC3_OP_SEQUENCER_IMM5_EN
  logic [5:0]  imm_q;

  always_comb begin
    legal_d = 1'b0;
    unique case (1'b1)
      (inst[15:12] == OP_ADD): legal_d = 1'b1;
      (inst[15:12] == OP_AND): legal_d = 1'b1;
      (inst[15:12] == OP_NOT): legal_d = 1'b1;
      default:                 legal_d = 1'b0;
    endcase
  end

  always_comb begin
    opb_d = rf_rd2;
    if (op_q == OP_NOT)
      opb_d = '0;
    else if (imm_q[5])
      opb_d = {{11{imm_q[4]}}, imm_q[4:0]};
  end
`else
  // imm5 forms are rejected at accept, so B is always SR2 here
  always_comb begin
    legal_d = 1'b0;
    unique case (1'b1)
      (inst[15:12] == OP_ADD): legal_d = !inst[5];
      (inst[15:12] == OP_AND): legal_d = !inst[5];
      (inst[15:12] == OP_NOT): legal_d = 1'b1;
      default:                 legal_d = 1'b0;
    endcase
  end

  always_comb begin
    opb_d = rf_rd2;
    if (op_q == OP_NOT)
      opb_d = '0;
  end
`endif

  always_comb begin
    cc_d = 3'b001;
    if (alu_out[15])
      cc_d = 3'b100;
    else if (alu_out == 16'h0000)
      cc_d = 3'b010;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dr_q     <= '0;
`ifdef LC3_OP_SEQUENCER_IMM5_EN
      imm_q    <= '0;
`endif
      ready_q  <= 1'b1;
      sr1_q    <= '0;
      sr2_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      we_q     <= 1'b0;
      rf_dr_q  <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      cc_q     <= 3'b010;
    end else begin
      sr1_q    <= '0;
      sr2_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      we_q     <= 1'b0;
      rf_dr_q  <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (inst_valid) begin
            op_q    <= inst[15:12];
            dr_q    <= inst[11:9];
`ifdef LC3_OP_SEQUENCER_IMM5_EN
            imm_q   <= inst[5:0];
`endif
            ready_q <= 1'b0;
            if (legal_d) begin
              state_q <= S_READ;
              sr1_q   <= inst[8:6];
              sr2_q   <= inst[2:0];
            end else begin
              state_q <= S_ILL;
              ill_q   <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q  <= S_EXEC;
          alu_op_q <= op_q;
          alu_a_q  <= rf_rd1;
          alu_b_q  <= opb_d;
        end
        S_EXEC: begin
          state_q <= S_WB;
          we_q    <= 1'b1;
          rf_dr_q <= dr_q;
          done_q  <= 1'b1;
        end
        S_WB: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          cc_q    <= cc_d;
        end
        S_ILL: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign inst_ready = ready_q;
  assign rf_sr1     = sr1_q;
  assign rf_sr2     = sr2_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rf_we      = we_q;
  assign rf_dr      = rf_dr_q;
  // ALU result only arrives during WB, so write data passes straight through
  assign rf_wd      = we_q ? alu_out : 16'h0000;
  assign cc         = cc_q;
  assign done       = done_q;
  assign illegal    = ill_q;

endmodule

// File: doc/lc3_op_sequencer.md
LC3_OP_SEQUENCER -- requirements
Module: lc3_op_sequencer

Interface
REQ-001 SHALL have no parameters; all data paths are 16 bits.
REQ-002 SHALL provide clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL provide rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide inst_valid  input  1  instruction offered.
REQ-005 SHALL provide inst  input  16  LC-3 instruction word.
REQ-006 SHALL provide inst_ready  output  1  high only in IDLE.
REQ-007 SHALL provide rf_sr1, rf_sr2  output  3 each  register-file read addresses.
REQ-008 SHALL provide rf_rd1, rf_rd2  input  16 each  combinational register-file read data.
REQ-009 SHALL provide alu_a, alu_b  output  16 each, and alu_op  output  4  ALU operands and opcode.
REQ-010 SHALL provide alu_out  input  16  ALU result, registered inside the ALU (valid one cycle after operands and opcode are presented).
REQ-011 SHALL provide rf_we  output  1, rf_dr  output  3, rf_wd  output  16  register-file write port.
REQ-012 SHALL provide cc  output  3  {N,Z,P} condition-code register.
REQ-013 SHALL provide done  output  1 and illegal  output  1, each a one-cycle pulse.

Function
REQ-014 SHALL implement states IDLE, READ, EXEC, WB, ILL.
REQ-015 SHALL accept an instruction in IDLE when inst_valid=1 (inst_ready=1 there); SHALL latch inst on that edge.
REQ-016 SHALL decode legal opcodes inst[15:12]: 0001 ADD, 0101 AND, 1001 NOT; all other opcodes go IDLE->ILL.
REQ-017 In ILL, illegal SHALL be 1 for one cycle with no rf_we or cc change; next state IDLE.
REQ-018 On a legal opcode, next state is READ; READ drives rf_sr1=inst[8:6] and rf_sr2=inst[2:0], and captures rf_rd1/rf_rd2 into operand registers at the end of READ.
REQ-019 Operand B SHALL be sign-extended inst[4:0] when inst[5]=1 (ADD/AND), else the captured rf_rd2; for NOT, B=0 and inst[5:0] is ignored.
REQ-020 EXEC SHALL drive alu_op=inst[15:12], alu_a=operand A, alu_b=operand B for exactly one cycle; outside EXEC, alu_op=0000 and alu_a=alu_b=0.
REQ-021 WB SHALL assert rf_we=1, rf_dr=inst[11:9], rf_wd=alu_out, and done=1 for one cycle; next state IDLE.
REQ-022 cc SHALL update at the end of WB, one-hot: N=alu_out[15]; Z=(alu_out==0); P=otherwise.
REQ-023 Latency: accept edge at cycle k -> WB during cycle k+3; throughput is one instruction per 4 cycles.
REQ-024 inst_valid SHALL be ignored outside IDLE; instructions held across the handshake are not re-accepted.
REQ-025 rf_sr1/rf_sr2 SHALL be 0 outside READ; rf_we, done and illegal SHALL be 0 except as stated.
REQ-026 A legal instruction with DR equal to SR1/SR2 SHALL use pre-write operand values; back-to-back dependencies need no forwarding, given the 4-cycle spacing.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, cc=3'b010, and rf_we=done=illegal=0 with all address/data outputs at 0.
REQ-028 Reset mid-operation SHALL abandon the instruction with no write-back and no cc update.
REQ-029 inst_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro LC3_OP_SEQUENCER_IMM5_EN defined: immediate mode per REQ-019.
REQ-031 Macro LC3_OP_SEQUENCER_IMM5_EN undefined: ADD/AND with inst[5]=1 SHALL be treated as illegal (IDLE->ILL); register mode and NOT are unchanged.

Verification
REQ-032 R1=5, R2=3; ADD R0,R1,R2 (0x1042) -> WB at k+3, rf_dr=0, rf_wd=8, cc=001, done pulse.
REQ-033 With IMM5_EN, R1=2; ADD R3,R1,#-2 (0x167E) -> rf_wd=0, cc=010; without IMM5_EN -> illegal pulse, no rf_we.
REQ-034 R4=0x00FF; NOT R5,R4 (0x9B3F) -> rf_wd=0xFF00, cc=100.
REQ-035 Opcode 0x0 or 0xF instruction -> illegal pulse one cycle after accept, cc unchanged, inst_ready back to 1 the following cycle.
REQ-036 Drop rst_n during EXEC of an ADD -> no rf_we ever asserted for it, cc=010, inst_ready=1 after release.
